// File: rtl/float_copro_arbiter.sv
// Round-robin arbiter sharing one float_copro among NREQ requesters.
// Enforces the copro's valid-low gap between operations and aborts operations that never complete.
module float_copro_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 63,
  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*11-1:0]   req_opcode,
  input  logic [NREQ*32-1:0]   req_op0,
  input  logic [NREQ*32-1:0]   req_op1,
  output logic [NREQ-1:0]      req_done,
  output logic                 req_err,
  output logic [31:0]          rsp_result,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 copro_valid,
  output logic [10:0]          copro_opcode,
  output logic [31:0]          copro_op0,
  output logic [31:0]          copro_op1,
  input  logic                 copro_complete,
  input  logic [31:0]          copro_result
);

  localparam int unsigned OPC_W = 11;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   done_d;
  logic              err_d;
  logic [DW-1:0]     result_d;
  logic [IDX_W-1:0]  grant_d;
  logic              valid_d;
  logic              busy_d;
  logic [OPC_W-1:0]  opcode_d;
  logic [DW-1:0]     op0_d, op1_d;

  logic [OPC_W-1:0]  opc_arr [NREQ];
  logic [DW-1:0]     op0_arr [NREQ];
  logic [DW-1:0]     op1_arr [NREQ];

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  int unsigned       scan_j;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign opc_arr[g] = req_opcode[OPC_W*g +: OPC_W];
    assign op0_arr[g] = req_op0[DW*g +: DW];
    assign op1_arr[g] = req_op1[DW*g +: DW];
  end

  // Round-robin pick: first pending request after the last grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_idx;
    scan_j     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_j = (32'(grant_idx) + i) % NREQ;
      if (!pick_found && req_valid[IDX_W'(scan_j)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan_j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    result_d = rsp_result;
    grant_d  = grant_idx;
    valid_d  = copro_valid;
    opcode_d = copro_opcode;
    op0_d    = copro_op0;
    op1_d    = copro_op1;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = BUSY;
          grant_d  = pick_idx;
          valid_d  = 1'b1;
          cnt_d    = '0;
          opcode_d = opc_arr[pick_idx];
          op0_d    = op0_arr[pick_idx];
          op1_d    = op1_arr[pick_idx];
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion takes precedence over a coincident timeout.
        if (copro_complete) begin
          result_d          = copro_result;
          done_d[grant_idx] = 1'b1;
          valid_d           = 1'b0;
          state_d           = RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d          = '0;
          done_d[grant_idx] = 1'b1;
          err_d             = 1'b1;
          valid_d           = 1'b0;
          state_d           = RELEASE;
        end
      end
      RELEASE: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_done     <= '0;
      req_err      <= 1'b0;
      rsp_result   <= '0;
      busy         <= 1'b0;
      grant_idx    <= IDX_W'(NREQ - 1);
      copro_valid  <= 1'b0;
      copro_opcode <= '0;
      copro_op0    <= '0;
      copro_op1    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_done     <= done_d;
      req_err      <= err_d;
      rsp_result   <= result_d;
      busy         <= busy_d;
      grant_idx    <= grant_d;
      copro_valid  <= valid_d;
      copro_opcode <= opcode_d;
      copro_op0    <= op0_d;
      copro_op1    <= op1_d;
    end
  end

endmodule

// File: tb/tb_float_copro_arbiter.sv
// Bench for float_copro_arbiter: copro stub, activity monitor and a round-robin reference model.
module tb_float_copro_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 63;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][10:0] r_opc;
  logic [NREQ-1:0][31:0] r_a;
  logic [NREQ-1:0][31:0] r_b;
  logic [NREQ*11-1:0]    req_opcode;
  logic [NREQ*32-1:0]    req_op0;
  logic [NREQ*32-1:0]    req_op1;
  logic [NREQ-1:0]       req_done;
  logic                  req_err;
  logic [31:0]           rsp_result;
  logic                  busy;
  logic [IDX_W-1:0]      grant_idx;
  logic                  copro_valid;
  logic [10:0]           copro_opcode;
  logic [31:0]           copro_op0, copro_op1;
  logic                  copro_complete;
  logic [31:0]           copro_result;

  int total = 0;
  int bad   = 0;

  assign req_opcode = r_opc;
  assign req_op0    = r_a;
  assign req_op1    = r_b;

  always #5 clk = ~clk;

  float_copro_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_op0(req_op0), .req_op1(req_op1), .req_done(req_done), .req_err(req_err),
    .rsp_result(rsp_result), .busy(busy), .grant_idx(grant_idx),
    .copro_valid(copro_valid), .copro_opcode(copro_opcode), .copro_op0(copro_op0),
    .copro_op1(copro_op1), .copro_complete(copro_complete), .copro_result(copro_result)
  );

  // Stand-in for float_copro: known float cases plus a scrambled result otherwise.
  function automatic logic [31:0] fp_model(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b);
    if (opc == 11'h000 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (opc == 11'h001 && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (opc == 11'h002 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (opc == 11'h003 && a == 32'h3F80_0000 && b == 32'h4080_0000) return 32'h3E80_0000;
    return (a ^ {b[15:0], b[31:16]}) + {21'd0, opc} + 32'h1234_5678;
  endfunction

  bit hang = 1'b0;
  bit spur = 1'b0;
  int stub_cnt, stub_lat;
  bit stub_fired;

  always @(negedge clk) begin
    copro_complete = 1'b0;
    if (!rst_n || !copro_valid) begin
      stub_cnt   = 0;
      stub_fired = 1'b0;
      stub_lat   = $urandom_range(1, 6);
      if (spur) begin
        copro_complete = 1'b1;
        copro_result   = 32'hDEAD_BEEF;
      end
    end else if (!hang && !stub_fired) begin
      stub_cnt++;
      if (stub_cnt >= stub_lat) begin
        copro_complete = 1'b1;
        copro_result   = fp_model(copro_opcode, copro_op0, copro_op1);
        stub_fired     = 1'b1;
      end
    end
  end

  typedef struct { int idx; logic err; logic [31:0] res; } done_t;
  done_t done_q[$];
  int    grant_q[$];
  int    hi_len, last_hi_len, lo_len;
  int    min_gap = 1000;
  int    stab_err = 0;
  int    done_glitch = 0;
  bit    prev_valid, seen_fall;
  logic [10:0] s_opc;
  logic [31:0] s_op0, s_op1;

  // Records done pulses, grants, copro_valid high/low run lengths and operand stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      seen_fall  = 1'b0;
      hi_len     = 0;
      lo_len     = 0;
    end else begin
      if (req_done != '0) begin
        if ($countones(req_done) != 1) done_glitch++;
        for (int i = 0; i < NREQ; i++) begin
          if (req_done[IDX_W'(i)]) begin
            done_t d;
            d.idx = i; d.err = req_err; d.res = rsp_result;
            done_q.push_back(d);
          end
        end
      end else if (req_err) begin
        done_glitch++;
      end
      if (copro_valid && !prev_valid) begin
        grant_q.push_back(int'(grant_idx));
        if (seen_fall && lo_len < min_gap) min_gap = lo_len;
        hi_len = 1;
        s_opc = copro_opcode; s_op0 = copro_op0; s_op1 = copro_op1;
      end else if (copro_valid) begin
        hi_len++;
        if (copro_opcode !== s_opc || copro_op0 !== s_op0 || copro_op1 !== s_op1) stab_err++;
      end else if (prev_valid) begin
        last_hi_len = hi_len;
        seen_fall   = 1'b1;
        lo_len      = 1;
      end else begin
        lo_len++;
      end
      prev_valid = copro_valid;
    end
  end

  logic [NREQ-1:0] drop_mask = '1;

  // Waits for n recorded dones; served requesters listed in drop_mask withdraw after their done.
  task automatic wait_dones(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      req_valid = req_valid & ~(req_done & drop_mask);
      if (done_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic set_req(input logic [IDX_W-1:0] i, input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b);
    r_opc[i] = opc; r_a[i] = a; r_b[i] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    done_q.delete();
    grant_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (req_done !== '0) begin bad++; $display("FAIL rst_done: got %b want 0", req_done); end
    total++; if (req_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", req_err); end
    total++; if (rsp_result !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 0", rsp_result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (copro_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", copro_valid); end
    total++; if ({copro_opcode, copro_op0, copro_op1} !== 75'h0) begin bad++; $display("FAIL rst_copro_fields: got %h %h %h want 0", copro_opcode, copro_op0, copro_op1); end
    total++; if (grant_idx !== IDX_W'(NREQ - 1)) begin bad++; $display("FAIL rst_grant: got %0d want %0d", grant_idx, NREQ - 1); end
  endtask

  task automatic test_single_add();
    bit ok;
    set_req(0, 11'h000, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 3'b001;
    @(negedge clk); #1;
    total++; if (copro_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL add_latency: got valid=%b busy=%b want 1 1", copro_valid, busy); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL add_grant: got %0d want 0", grant_idx); end
    total++; if (copro_opcode !== 11'h000 || copro_op0 !== 32'h3F80_0000 || copro_op1 !== 32'h4000_0000) begin
      bad++; $display("FAIL add_fields: got %h %h %h want 000 3f800000 40000000", copro_opcode, copro_op0, copro_op1); end
    wait_dones(1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL add_wait: got no done want 1 done"); end
    total++; if (done_q.size() != 1 || done_q[0].idx != 0 || done_q[0].err !== 1'b0 || done_q[0].res !== 32'h4040_0000) begin
      bad++; $display("FAIL add_result: got n=%0d idx=%0d err=%b res=%h want 1 0 0 40400000", done_q.size(), done_q[0].idx, done_q[0].err, done_q[0].res); end
    @(negedge clk); #1;
    total++; if (req_done !== '0) begin bad++; $display("FAIL add_pulse_width: got %b want 0", req_done); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    min_gap = 1000;
    set_req(0, 11'h002, 32'h4000_0000, 32'h4040_0000);
    set_req(1, 11'h003, 32'h3F80_0000, 32'h4080_0000);
    req_valid = 3'b011;
    wait_dones(2, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_wait: got %0d dones want 2", done_q.size()); end
    total++; if (done_q[0].idx != 0 || done_q[0].res !== 32'h40C0_0000) begin
      bad++; $display("FAIL rr_first: got idx=%0d res=%h want 0 40c00000", done_q[0].idx, done_q[0].res); end
    total++; if (done_q[1].idx != 1 || done_q[1].res !== 32'h3E80_0000) begin
      bad++; $display("FAIL rr_second: got idx=%0d res=%h want 1 3e800000", done_q[1].idx, done_q[1].res); end
    total++; if (grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 1) begin
      bad++; $display("FAIL rr_grants: got n=%0d %0d,%0d want 0,1", grant_q.size(), grant_q[0], grant_q[1]); end
    total++; if (min_gap != 2) begin bad++; $display("FAIL rr_gap: got %0d want 2", min_gap); end
  endtask

  task automatic test_starvation();
    bit ok;
    do_reset();
    drop_mask = 3'b100;
    for (int i = 0; i < 2; i++) set_req(IDX_W'(i), 11'($urandom), $urandom, $urandom);
    req_valid = 3'b011;
    wait_dones(4, 200, ok);
    req_valid = '0;
    drop_mask = '1;
    repeat (4) @(negedge clk);
    total++; if (!ok || grant_q.size() != 4) begin bad++; $display("FAIL starve_count: got %0d grants want 4", grant_q.size()); end
    for (int k = 0; k < 4; k++) begin
      total++; if (grant_q[k] != (k % 2) || done_q[k].idx != (k % 2) ||
                   done_q[k].res !== fp_model(r_opc[IDX_W'(k % 2)], r_a[IDX_W'(k % 2)], r_b[IDX_W'(k % 2)])) begin
        bad++; $display("FAIL starve_op%0d: got grant=%0d done=%0d res=%h want %0d", k, grant_q[k], done_q[k].idx, done_q[k].res, k % 2); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    done_q.delete();
    hang = 1'b1;
    set_req(2, 11'($urandom), $urandom, $urandom);
    req_valid = 3'b100;
    wait_dones(1, 200, ok);
    hang = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL to_wait: got no done want 1"); end
    total++; if (last_hi_len != TIMEOUT) begin bad++; $display("FAIL to_valid_len: got %0d want %0d", last_hi_len, TIMEOUT); end
    total++; if (done_q[0].idx != 2 || done_q[0].err !== 1'b1 || done_q[0].res !== 32'h0) begin
      bad++; $display("FAIL to_done: got idx=%0d err=%b res=%h want 2 1 0", done_q[0].idx, done_q[0].err, done_q[0].res); end
    done_q.delete();
    set_req(0, 11'h000, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 3'b001;
    wait_dones(1, 50, ok);
    total++; if (!ok || done_q[0].idx != 0 || done_q[0].err !== 1'b0 || done_q[0].res !== 32'h4040_0000) begin
      bad++; $display("FAIL to_recover: got idx=%0d err=%b res=%h want 0 0 40400000", done_q[0].idx, done_q[0].err, done_q[0].res); end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    repeat (3) @(negedge clk);
    done_q.delete();
    hang = 1'b1;
    set_req(1, 11'h003, 32'h3F80_0000, 32'h4080_0000);
    req_valid = 3'b010;
    repeat (10) @(negedge clk);
    #1;
    total++; if (copro_valid !== 1'b1) begin bad++; $display("FAIL rmb_started: got %b want 1", copro_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (copro_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmb_async: got valid=%b busy=%b want 0 0", copro_valid, busy); end
    total++; if (grant_idx !== IDX_W'(NREQ - 1)) begin bad++; $display("FAIL rmb_grant: got %0d want %0d", grant_idx, NREQ - 1); end
    req_valid = '0;
    hang = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    total++; if (done_q.size() != 0 || req_done !== '0) begin bad++; $display("FAIL rmb_no_done: got %0d dones want 0", done_q.size()); end
    set_req(0, 11'h001, 32'h4040_0000, 32'h3F80_0000);
    req_valid = 3'b001;
    wait_dones(1, 50, ok);
    total++; if (!ok || done_q[0].idx != 0 || done_q[0].res !== 32'h4000_0000) begin
      bad++; $display("FAIL rmb_sub: got idx=%0d res=%h want 0 40000000", done_q[0].idx, done_q[0].res); end
  endtask

  task automatic test_withdraw();
    bit ok;
    bit seen;
    repeat (3) @(negedge clk);
    done_q.delete();
    grant_q.delete();
    set_req(1, 11'($urandom), $urandom, $urandom);
    req_valid = 3'b010;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #1;
      seen = copro_valid;
    end
    req_valid = '0;
    total++; if (!seen) begin bad++; $display("FAIL wd_grant: got no copro_valid want 1"); end
    wait_dones(1, 50, ok);
    total++; if (!ok || done_q[0].idx != 1 || done_q[0].res !== fp_model(r_opc[1], r_a[1], r_b[1])) begin
      bad++; $display("FAIL wd_done: got idx=%0d res=%h want 1 %h", done_q[0].idx, done_q[0].res, fp_model(r_opc[1], r_a[1], r_b[1])); end
    repeat (10) @(negedge clk);
    #1;
    total++; if (grant_q.size() != 1 || done_q.size() != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL wd_idle: got grants=%0d dones=%0d busy=%b want 1 1 0", grant_q.size(), done_q.size(), busy); end
  endtask

  task automatic test_spurious_complete();
    done_q.delete();
    spur = 1'b1;
    repeat (8) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (done_q.size() != 0 || busy !== 1'b0 || copro_valid !== 1'b0) begin
      bad++; $display("FAIL spur: got dones=%0d busy=%b valid=%b want 0 0 0", done_q.size(), busy, copro_valid); end
  endtask

  task automatic test_random();
    bit ok;
    int last;
    int exp_q[$];
    logic [NREQ-1:0] mask;
    do_reset();
    last = NREQ - 1;
    for (int b = 0; b < 20; b++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      exp_q.delete();
      for (int k = 1; k <= NREQ; k++) begin
        if (mask[IDX_W'((last + k) % NREQ)]) exp_q.push_back((last + k) % NREQ);
      end
      for (int i = 0; i < NREQ; i++) set_req(IDX_W'(i), 11'($urandom), $urandom, $urandom);
      done_q.delete();
      req_valid = mask;
      wait_dones(exp_q.size(), 300, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd_wait%0d: got %0d dones want %0d", b, done_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
        total++; if (done_q[k].idx != exp_q[k] || done_q[k].err !== 1'b0 ||
                     done_q[k].res !== fp_model(r_opc[IDX_W'(exp_q[k])], r_a[IDX_W'(exp_q[k])], r_b[IDX_W'(exp_q[k])])) begin
          bad++; $display("FAIL rnd_b%0d_op%0d: got idx=%0d res=%h want idx=%0d", b, k, done_q[k].idx, done_q[k].res, exp_q[k]); end
      end
      last = exp_q[exp_q.size() - 1];
    end
    total++; if (min_gap < 2) begin bad++; $display("FAIL gap_min: got %0d want >=2", min_gap); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL copro_stable: got %0d changes want 0", stab_err); end
    total++; if (done_glitch != 0) begin bad++; $display("FAIL done_onehot: got %0d glitches want 0", done_glitch); end
  endtask

  initial begin
    rst_n          = 1'b0;
    req_valid      = '0;
    r_opc          = '0;
    r_a            = '0;
    r_b            = '0;
    copro_complete = 1'b0;
    copro_result   = '0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_starvation();
    test_timeout();
    test_reset_mid_busy();
    test_withdraw();
    test_spurious_complete();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
